// File: rtl/pr_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : pr_rr_arbiter
//  Brief    : Round-robin arbiter with registered one-hot grant, rotating
//             priority pointer and hold-limit forced release.
//  Revision : 1.0 - initial release
// ============================================================================
module pr_rr_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_valid,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 timeout
);

    localparam int c_ID_W = $clog2(N);
    localparam int c_HC_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [c_HC_W-1:0] c_HOLD_LAST = c_HC_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [N-1:0]      c_ONE       = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t              r_state;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_HC_W-1:0]   r_hold_cnt;
    logic [N-1:0]        r_grant;
    logic                r_grant_valid;
    logic [c_ID_W-1:0]   r_grant_id;
    logic                r_timeout;

    logic [N-1:0]        w_cand;
    logic [N-1:0]        w_rot;
    logic [N-1:0]        w_rot_oh;
    logic [N-1:0]        w_win_oh;
    logic [c_ID_W-1:0]   w_win_id;
    logic                w_any;
    logic                w_hold_req;
    logic                w_timeout_due;

    // The current holder is masked out: on a release its bit is already low,
    // on a timeout it must lose to any other requester.
    assign w_cand        = req & ~r_grant;
    assign w_any         = |w_cand;
    assign w_hold_req    = req[r_grant_id];
    assign w_timeout_due = (MAX_HOLD != 0) && w_hold_req && (r_hold_cnt == c_HOLD_LAST);

    always_comb begin
        w_rot    = '0;
        w_win_oh = '0;
        w_win_id = '0;
        for (int i = 0; i < N; i++) begin
            w_rot[i] = w_cand[c_ID_W'(i) + r_ptr];
        end
        w_rot_oh = w_rot & (~w_rot + c_ONE);
        for (int i = 0; i < N; i++) begin
            w_win_oh[i] = w_rot_oh[c_ID_W'(i) - r_ptr];
        end
        for (int i = 0; i < N; i++) begin
            if (w_win_oh[i]) begin
                w_win_id = w_win_id | c_ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_ptr         <= '0;
            r_hold_cnt    <= '0;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant       <= w_win_oh;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_win_id;
                        r_ptr         <= w_win_id + c_ID_W'(1);
                        r_hold_cnt    <= '0;
                        r_state       <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_hold_req) begin
                        r_hold_cnt <= '0;
                        if (w_any) begin
                            r_grant    <= w_win_oh;
                            r_grant_id <= w_win_id;
                            r_ptr      <= w_win_id + c_ID_W'(1);
                        end else begin
                            r_grant       <= '0;
                            r_grant_valid <= 1'b0;
                            r_grant_id    <= '0;
                            r_state       <= ST_IDLE;
                        end
                    end else if (w_timeout_due) begin
                        r_timeout  <= 1'b1;
                        r_hold_cnt <= '0;
                        if (w_any) begin
                            r_grant    <= w_win_oh;
                            r_grant_id <= w_win_id;
                            r_ptr      <= w_win_id + c_ID_W'(1);
                        end else begin
                            r_ptr <= r_grant_id + c_ID_W'(1);
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + c_HC_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_grant_valid;
    assign grant_id    = r_grant_id;
    assign timeout     = r_timeout;

endmodule
`default_nettype wire

// File: doc/pr_rr_arbiter.md
# pr_rr_arbiter

Round-robin arbiter that shares one resource among N requesters, built around the team's one-hot priority encoder. Each cycle it rotates the request vector by a registered pointer, picks the first active requester with a one-hot priority encode, and registers the result as the grant. A grant is held until the requester drops its request or a hold-limit timeout forces a release. It sits between request sources and a shared datapath resource, and its grant output drives the resource's select/enable.

## Interface
- `N`, default 8: number of requesters; must be a power of two ≥ 2.
- `MAX_HOLD`, default 16: maximum number of consecutive cycles one grant may be held; 0 disables the timeout.
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, N: request vector; bit i is high while requester i wants the resource.
- `grant`, output, N: registered one-hot grant, or all zeros when idle.
- `grant_valid`, output, 1: registered; equals `|grant`.
- `grant_id`, output, $clog2(N): registered index of the granted bit; 0 when idle.
- `timeout`, output, 1: registered one-cycle pulse marking a forced release.

## Operation
- Internal state:
  - `state` ∈ {IDLE, GRANT}.
  - `ptr` is $clog2(N) bits: the highest-priority index for the next arbitration.
  - `hold_cnt` is $clog2(MAX_HOLD+1) bits.
- Winner selection:
  - Search candidate bits starting at `ptr` and ascending with wrap (index arithmetic modulo N).
  - Implement as rotate-right by `ptr`, then a one-hot priority encode with bit 0 as highest priority, then rotate-left by `ptr`.
- IDLE:
  - If `req`==0: stay in IDLE.
  - Otherwise, at the edge, load the winner from `req` into `grant` and `grant_id`, set `ptr` = winner+1 mod N, clear `hold_cnt`, and go to GRANT.
- GRANT, normal release:
  - If `req[grant_id]`==0 at the edge, arbitrate among `req`. The dropped bit is low, so it is excluded naturally.
  - If a winner exists, grant it back-to-back with no idle cycle: set `ptr` = winner+1, clear `hold_cnt`.
  - If no winner exists, clear `grant` and go to IDLE.
- GRANT, hold:
  - Applies when `req[grant_id]`==1 and no timeout is due.
  - `grant` is unchanged; `hold_cnt` += 1.
- GRANT, timeout:
  - Due when `MAX_HOLD`≠0, `req[grant_id]`==1 and `hold_cnt`==MAX_HOLD-1 at the edge.
  - Arbitrate among `req` with bit `grant_id` masked off.
  - If a winner exists, grant it.
  - If no winner exists, re-grant the same id.
  - In both cases clear `hold_cnt`, set `ptr` = new id+1, and drive `timeout`=1 for exactly the following cycle.
- Invariants, checked on every edge after reset:
  - `grant` is $onehot0.
  - `grant_valid` == |`grant`.
  - `grant` == (`grant_valid` << `grant_id`).
  - No output is ever X or Z.
  - A request that stays asserted is granted within N·max(MAX_HOLD,1) cycles. With MAX_HOLD=0 this bound holds only if holders release.
- `req` containing X/Z is illegal stimulus. The design does not need to tolerate it, but `grant` must be known again after the next reset.

## Timing
- Reset values (asserting `rst_n` low clears these immediately, regardless of clock):
  - `grant`=0, `grant_valid`=0, `grant_id`=0, `timeout`=0.
  - `ptr`=0, `hold_cnt`=0, `state`=IDLE.
- Reset mid-grant:
  - Outputs drop in the same cycle.
  - After `rst_n` rises, the first arbitration starts from `ptr`=0.
- Grant latency: `req` sampled at edge k ⇒ `grant` visible from edge k (registered) through the cycle that follows.
- Release latency: requester lowers `req` during cycle c ⇒ at the edge ending c, `grant` moves to the next winner or to 0.
- Hold limit: a grant is visible for at most MAX_HOLD cycles. `timeout` is high during the first cycle of the replacement grant.
- Simultaneous events:
  - A requester may drop while others raise requests in the same cycle. They all take part in that edge's arbitration.
  - A release on the exact cycle the timeout would fire is a normal release: `timeout` stays 0.

## Test plan
- Reset/idle:
  - Hold `rst_n`=0 for 3 cycles with `req`=8'hFF ⇒ all outputs 0.
  - Release reset with `req`=8'h00 ⇒ outputs stay 0, no X.
- Basic grant (ptr=0, from reset):
  - `req`=8'b1000_0100 ⇒ next edge `grant`=8'b0000_0100, `grant_id`=2.
  - Drop bit 2 ⇒ next edge `grant`=8'b1000_0000, `grant_id`=7.
  - Drop bit 7 ⇒ `grant`=0.
- Rotation:
  - Setup: `req`=8'hFF; each grantee drops its request for one cycle after being granted, then reasserts.
  - Required: `grant_id` sequence 0,1,2,…,7,0,1 with no idle cycles.
- Timeout, two requesters (MAX_HOLD=4):
  - `req`=8'b0000_0011 held constant.
  - Required: bit 0 granted for 4 cycles, then bit 1 with a `timeout` pulse, then after 4 cycles bit 0 with a `timeout` pulse, repeating.
- Timeout, single requester (MAX_HOLD=4):
  - `req`=8'b0000_1000 held.
  - Required: `grant` stays 8'b0000_1000, `grant_valid` never drops, `timeout` pulses every 4th cycle.
- Randomised run:
  - Drive 200 cycles of $random `req`, including an asynchronous reset mid-grant.
  - Check every cycle: the onehot0, `grant_id` consistency and no-X invariants, and the starvation bound.
